s_axi_reg_bank: RTL and testbench

Parametrised AXI4 slave register bank holding NUM_REGS registers of DATA_W bits, for single-beat access only.
- Fully implements the write-address, write-data, write-response, read-address and read-data channels.
- Supports byte strobes, per-register read-only protection and error responses.
- Exposes all register contents to the fabric so AXI-configured control blocks (e.g. counters) can use them.

---
 rtl/s_axi_reg_pkg.sv | 39 +++
 rtl/s_axi_reg_bank.sv | 248 ++++++++++++++++++++++++
 tb/tb_s_axi_reg_bank.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/s_axi_reg_pkg.sv
// Shared types and address decode for the AXI4 register bank.
package s_axi_reg_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_HAVE_A = 2'd1,
    W_HAVE_D = 2'd2,
    W_RESP   = 2'd3
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  // True when the byte address falls inside the register window.
  function automatic logic addr_in_range(input logic [63:0] addr,
                                         input int unsigned lsb,
                                         input int unsigned num_regs);
    return (addr >> lsb) < 64'(num_regs);
  endfunction

  // Register index; sub-word address bits are discarded.
  function automatic int unsigned addr_index(input logic [63:0] addr,
                                             input int unsigned lsb,
                                             input int unsigned num_regs);
    logic [63:0] word;
    word = (addr >> lsb) & 64'(num_regs - 1);
    return word[31:0];
  endfunction

endpackage

// File: rtl/s_axi_reg_bank.sv
// Single-beat AXI4 slave register bank with byte strobes, read-only
// protection and decode errors; all registers exported on regs_o.
module s_axi_reg_bank
  import s_axi_reg_pkg::*;
#(
  parameter int unsigned          DATA_W    = 32,
  parameter int unsigned          ADDR_W    = 32,
  parameter int unsigned          ID_W      = 4,
  parameter int unsigned          NUM_REGS  = 8,
  parameter logic [DATA_W-1:0]    RESET_VAL = '0,
  parameter logic [NUM_REGS-1:0]  RO_MASK   = '0
) (
  input  logic                       clk,
  input  logic                       areset,
  input  logic [ID_W-1:0]            awid_i,
  input  logic [ADDR_W-1:0]          awaddr_i,
  input  logic                       awvalid_i,
  output logic                       awready_o,
  input  logic [DATA_W-1:0]          wdata_i,
  input  logic [DATA_W/8-1:0]        wstrb_i,
  input  logic                       wlast_i,
  input  logic                       wvalid_i,
  output logic                       wready_o,
  output logic [ID_W-1:0]            bid_o,
  output logic [1:0]                 bresp_o,
  output logic                       bvalid_o,
  input  logic                       bready_i,
  input  logic [ID_W-1:0]            arid_i,
  input  logic [ADDR_W-1:0]          araddr_i,
  input  logic                       arvalid_i,
  output logic                       arready_o,
  output logic [ID_W-1:0]            rid_o,
  output logic [DATA_W-1:0]          rdata_o,
  output logic [1:0]                 rresp_o,
  output logic                       rlast_o,
  output logic                       rvalid_o,
  input  logic                       rready_i,
  output logic [NUM_REGS*DATA_W-1:0] regs_o
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned LSB    = $clog2(STRB_W);
  localparam int unsigned IDX_W  = $clog2(NUM_REGS);

  wr_state_t           wr_state_q, wr_state_d;
  logic                awready_q, awready_d, wready_q, wready_d;
  logic                bvalid_q, bvalid_d;
  logic [ID_W-1:0]     bid_q, bid_d;
  resp_t               bresp_q, bresp_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic [ID_W-1:0]     awid_q, awid_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];

  rd_state_t           rd_state_q, rd_state_d;
  logic                arready_q, arready_d, rvalid_q, rvalid_d;
  logic [ID_W-1:0]     rid_q, rid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  resp_t               rresp_q, rresp_d;

  logic                commit;
  logic [ADDR_W-1:0]   c_addr;
  logic [ID_W-1:0]     c_id;
  logic [DATA_W-1:0]   c_data;
  logic [STRB_W-1:0]   c_strb;
  logic                c_ok, ar_ok;
  logic [IDX_W-1:0]    c_idx, ar_idx;

  logic aw_hs, w_hs, ar_hs;
  assign aw_hs = awvalid_i & awready_q;
  assign w_hs  = wvalid_i  & wready_q;
  assign ar_hs = arvalid_i & arready_q;

  // Each W beat is a complete transaction, so the last flag carries no information.
  logic unused_wlast;
  assign unused_wlast = wlast_i;

  // Write channel: collect AW and W in either order, commit, then hold the response.
  always_comb begin
    wr_state_d = wr_state_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    bvalid_d   = bvalid_q;
    bid_d      = bid_q;
    bresp_d    = bresp_q;
    awaddr_d   = awaddr_q;
    awid_d     = awid_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    regs_d     = regs_q;
    commit     = 1'b0;
    c_addr     = awaddr_i;
    c_id       = awid_i;
    c_data     = wdata_i;
    c_strb     = wstrb_i;

    case (wr_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit = 1'b1;
        end else if (aw_hs) begin
          awaddr_d   = awaddr_i;
          awid_d     = awid_i;
          awready_d  = 1'b0;
          wr_state_d = W_HAVE_A;
        end else if (w_hs) begin
          wdata_d    = wdata_i;
          wstrb_d    = wstrb_i;
          wready_d   = 1'b0;
          wr_state_d = W_HAVE_D;
        end
      end
      W_HAVE_A: begin
        c_addr = awaddr_q;
        c_id   = awid_q;
        commit = w_hs;
      end
      W_HAVE_D: begin
        c_data = wdata_q;
        c_strb = wstrb_q;
        commit = aw_hs;
      end
      W_RESP: begin
        if (bready_i) begin
          bvalid_d   = 1'b0;
          awready_d  = 1'b1;
          wready_d   = 1'b1;
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase

    c_ok  = addr_in_range(64'(c_addr), LSB, NUM_REGS);
    c_idx = IDX_W'(addr_index(64'(c_addr), LSB, NUM_REGS));

    if (commit) begin
      wr_state_d = W_RESP;
      awready_d  = 1'b0;
      wready_d   = 1'b0;
      bvalid_d   = 1'b1;
      bid_d      = c_id;
      if (!c_ok) begin
        bresp_d = DECERR;
      end else if (RO_MASK[c_idx]) begin
        bresp_d = SLVERR;
      end else begin
        bresp_d = OKAY;
        for (int k = 0; k < STRB_W; k++) begin
          if (c_strb[k]) regs_d[c_idx][k*8 +: 8] = c_data[k*8 +: 8];
        end
      end
    end
  end

  // Read channel: sample the pre-commit register array on the AR handshake.
  always_comb begin
    rd_state_d = rd_state_q;
    arready_d  = arready_q;
    rvalid_d   = rvalid_q;
    rid_d      = rid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    ar_ok      = addr_in_range(64'(araddr_i), LSB, NUM_REGS);
    ar_idx     = IDX_W'(addr_index(64'(araddr_i), LSB, NUM_REGS));

    case (rd_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          rid_d      = arid_i;
          rdata_d    = ar_ok ? regs_q[ar_idx] : '0;
          rresp_d    = ar_ok ? OKAY : DECERR;
          rvalid_d   = 1'b1;
          arready_d  = 1'b0;
          rd_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (rready_i) begin
          rvalid_d   = 1'b0;
          arready_d  = 1'b1;
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // State and output registers; reset abandons any partial transaction.
  always_ff @(posedge clk) begin
    if (areset) begin
      wr_state_q <= W_IDLE;
      awready_q  <= 1'b1;
      wready_q   <= 1'b1;
      bvalid_q   <= 1'b0;
      bid_q      <= '0;
      bresp_q    <= OKAY;
      awaddr_q   <= '0;
      awid_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b1;
      rvalid_q   <= 1'b0;
      rid_q      <= '0;
      rdata_q    <= '0;
      rresp_q    <= OKAY;
    end else begin
      wr_state_q <= wr_state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bid_q      <= bid_d;
      bresp_q    <= bresp_d;
      awaddr_q   <= awaddr_d;
      awid_q     <= awid_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      regs_q     <= regs_d;
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rid_q      <= rid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  assign awready_o = awready_q;
  assign wready_o  = wready_q;
  assign bvalid_o  = bvalid_q;
  assign bid_o     = bid_q;
  assign bresp_o   = bresp_q;
  assign arready_o = arready_q;
  assign rvalid_o  = rvalid_q;
  assign rlast_o   = rvalid_q;
  assign rid_o     = rid_q;
  assign rdata_o   = rdata_q;
  assign rresp_o   = rresp_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
    assign regs_o[g*DATA_W +: DATA_W] = regs_q[g];
  end

endmodule

// File: tb/tb_s_axi_reg_bank.sv
// Directed bench for s_axi_reg_bank: vector table plus multi-cycle corner cases.
module tb_s_axi_reg_bank;

  localparam int unsigned        DW   = 32;
  localparam int unsigned        AW   = 32;
  localparam int unsigned        IW   = 4;
  localparam int unsigned        NR   = 8;
  localparam logic [DW-1:0]      RVAL = 32'hC0DE_0000;
  localparam logic [NR-1:0]      ROM  = 8'h01;

  logic            clk = 1'b0;
  logic            areset;
  logic [IW-1:0]   awid, arid, bid, rid;
  logic [AW-1:0]   awaddr, araddr;
  logic            awvalid, awready, wvalid, wready, wlast;
  logic [DW-1:0]   wdata, rdata;
  logic [3:0]      wstrb;
  logic [1:0]      bresp, rresp;
  logic            bvalid, bready, arvalid, arready, rvalid, rready, rlast;
  logic [NR*DW-1:0] regs;
  logic [NR*DW-1:0] exp_regs;

  int n_chk  = 0;
  int n_fail = 0;

  s_axi_reg_bank #(
    .DATA_W(DW), .ADDR_W(AW), .ID_W(IW), .NUM_REGS(NR),
    .RESET_VAL(RVAL), .RO_MASK(ROM)
  ) dut (
    .clk(clk), .areset(areset),
    .awid_i(awid), .awaddr_i(awaddr), .awvalid_i(awvalid), .awready_o(awready),
    .wdata_i(wdata), .wstrb_i(wstrb), .wlast_i(wlast), .wvalid_i(wvalid), .wready_o(wready),
    .bid_o(bid), .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready),
    .arid_i(arid), .araddr_i(araddr), .arvalid_i(arvalid), .arready_o(arready),
    .rid_o(rid), .rdata_o(rdata), .rresp_o(rresp), .rlast_o(rlast),
    .rvalid_o(rvalid), .rready_i(rready), .regs_o(regs)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  id;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] val;   // read data, or target register value after a write
    int          idx;   // target register for writes
  } vec_t;

  localparam int NV = 14;
  vec_t vec [NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [3:0] id,
                          input logic [31:0] d, input logic [3:0] s);
    chk("awready_pre", 256'(awready), 256'(1'b1));
    chk("wready_pre", 256'(wready), 256'(1'b1));
    awvalid = 1'b1; awaddr = a; awid = id;
    wvalid  = 1'b1; wdata  = d; wstrb = s; wlast = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic finish_b();
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("bvalid_drop", 256'(bvalid), 256'(1'b0));
    chk("awready_back", 256'(awready), 256'(1'b1));
    chk("wready_back", 256'(wready), 256'(1'b1));
  endtask

  task automatic do_read(input logic [31:0] a, input logic [3:0] id,
                         input logic [31:0] ed, input logic [1:0] er);
    chk("arready_pre", 256'(arready), 256'(1'b1));
    arvalid = 1'b1; araddr = a; arid = id;
    tick();
    arvalid = 1'b0;
    chk("rvalid", 256'(rvalid), 256'(1'b1));
    chk("rlast", 256'(rlast), 256'(1'b1));
    chk("rid", 256'(rid), 256'(id));
    chk("rdata", 256'(rdata), 256'(ed));
    chk("rresp", 256'(rresp), 256'(er));
    rready = 1'b1;
    tick();
    rready = 1'b0;
    chk("rvalid_drop", 256'(rvalid), 256'(1'b0));
    chk("arready_back", 256'(arready), 256'(1'b1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //        wr    addr    id    data           strb  resp   val            idx
    vec[0]  = '{1'b1, 32'h08, 4'd3, 32'hDEADBEEF, 4'hF, 2'b00, 32'hDEADBEEF, 2};
    vec[1]  = '{1'b0, 32'h08, 4'd5, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF, 0};
    vec[2]  = '{1'b1, 32'h04, 4'd1, 32'hFFFFFFFF, 4'hF, 2'b00, 32'hFFFFFFFF, 1};
    vec[3]  = '{1'b1, 32'h00, 4'd2, 32'h00001234, 4'hF, 2'b10, 32'hC0DE0000, 0};
    vec[4]  = '{1'b0, 32'h00, 4'd6, 32'h0,        4'h0, 2'b00, 32'hC0DE0000, 0};
    vec[5]  = '{1'b1, 32'h20, 4'd7, 32'h00000055, 4'hF, 2'b11, 32'h0,        0};
    vec[6]  = '{1'b0, 32'h20, 4'd8, 32'h0,        4'h0, 2'b11, 32'h00000000, 0};
    vec[7]  = '{1'b1, 32'h0C, 4'd9, 32'h12345678, 4'h0, 2'b00, 32'hC0DE0000, 3};
    vec[8]  = '{1'b0, 32'h0C, 4'd10, 32'h0,       4'h0, 2'b00, 32'hC0DE0000, 0};
    vec[9]  = '{1'b1, 32'h0E, 4'd11, 32'hAABBCCDD, 4'hC, 2'b00, 32'hAABB0000, 3};
    vec[10] = '{1'b0, 32'h0F, 4'd12, 32'h0,       4'h0, 2'b00, 32'hAABB0000, 0};
    vec[11] = '{1'b1, 32'h1C, 4'd13, 32'h01020304, 4'hF, 2'b00, 32'h01020304, 7};
    vec[12] = '{1'b0, 32'h1C, 4'd14, 32'h0,       4'h0, 2'b00, 32'h01020304, 0};
    vec[13] = '{1'b0, 32'h40, 4'd15, 32'h0,       4'h0, 2'b11, 32'h00000000, 0};

    areset = 1'b1;
    awid = '0; awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0;
    wvalid = 1'b0; bready = 1'b0; arid = '0; araddr = '0; arvalid = 1'b0; rready = 1'b0;
    exp_regs = {NR{RVAL}};
    tick();
    tick();
    areset = 1'b0;

    // Reset state
    chk("rst_awready", 256'(awready), 256'(1'b1));
    chk("rst_wready", 256'(wready), 256'(1'b1));
    chk("rst_arready", 256'(arready), 256'(1'b1));
    chk("rst_bvalid", 256'(bvalid), 256'(1'b0));
    chk("rst_rvalid", 256'(rvalid), 256'(1'b0));
    chk("rst_bid_bresp", 256'({bid, bresp}), 256'(0));
    chk("rst_rid_rresp_rdata", 256'({rid, rresp, rdata}), 256'(0));
    chk("rst_regs", 256'(regs), 256'(exp_regs));

    // Vector table
    for (int i = 0; i < NV; i++) begin
      if (vec[i].wr) begin
        do_write(vec[i].addr, vec[i].id, vec[i].data, vec[i].strb);
        chk("bvalid", 256'(bvalid), 256'(1'b1));
        chk("bid", 256'(bid), 256'(vec[i].id));
        chk("bresp", 256'(bresp), 256'(vec[i].resp));
        if (vec[i].resp != 2'b11) exp_regs[vec[i].idx*DW +: DW] = vec[i].val;
        chk("regs_after_write", 256'(regs), 256'(exp_regs));
        finish_b();
      end else begin
        do_read(vec[i].addr, vec[i].id, vec[i].val, vec[i].resp);
      end
    end

    // W three cycles ahead of AW, partial strobe onto reg1 (0xFFFFFFFF)
    wvalid = 1'b1; wdata = 32'h11223344; wstrb = 4'b0101; wlast = 1'b1;
    tick();
    wvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("wfirst_wready_low", 256'(wready), 256'(1'b0));
      chk("wfirst_awready_high", 256'(awready), 256'(1'b1));
      chk("wfirst_no_bvalid", 256'(bvalid), 256'(1'b0));
      if (c < 2) tick();
    end
    awvalid = 1'b1; awaddr = 32'h04; awid = 4'd4;
    tick();
    awvalid = 1'b0;
    chk("wfirst_bvalid", 256'(bvalid), 256'(1'b1));
    chk("wfirst_bid", 256'(bid), 256'(4'd4));
    chk("wfirst_bresp", 256'(bresp), 256'(2'b00));
    exp_regs[1*DW +: DW] = 32'hFF22FF44;
    chk("wfirst_regs", 256'(regs), 256'(exp_regs));
    finish_b();

    // Backpressure on B and R, with a read colliding with the commit to reg5
    awvalid = 1'b1; awaddr = 32'h14; awid = 4'd6;
    wvalid = 1'b1; wdata = 32'h0BADF00D; wstrb = 4'hF;
    arvalid = 1'b1; araddr = 32'h14; arid = 4'd9;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    exp_regs[5*DW +: DW] = 32'h0BADF00D;
    for (int c = 0; c < 5; c++) begin
      chk("bp_bvalid", 256'(bvalid), 256'(1'b1));
      chk("bp_bid_bresp", 256'({bid, bresp}), 256'({4'd6, 2'b00}));
      chk("bp_readies_low", 256'({awready, wready}), 256'(2'b00));
      chk("bp_rvalid", 256'(rvalid), 256'(1'b1));
      chk("bp_rdata_old", 256'(rdata), 256'(32'hC0DE0000));
      chk("bp_rid_rresp", 256'({rid, rresp}), 256'({4'd9, 2'b00}));
      tick();
    end
    chk("bp_regs", 256'(regs), 256'(exp_regs));
    rready = 1'b1;
    tick();
    rready = 1'b0;
    chk("bp_rvalid_drop", 256'(rvalid), 256'(1'b0));
    finish_b();
    do_read(32'h14, 4'd2, 32'h0BADF00D, 2'b00);

    // Reset while holding an address: everything reverts, stale AW is lost
    awvalid = 1'b1; awaddr = 32'h18; awid = 4'd2;
    tick();
    awvalid = 1'b0;
    chk("rst_mid_awready_low", 256'(awready), 256'(1'b0));
    areset = 1'b1;
    tick();
    areset = 1'b0;
    exp_regs = {NR{RVAL}};
    chk("rst_mid_readies", 256'({awready, wready, arready}), 256'(3'b111));
    chk("rst_mid_valids", 256'({bvalid, rvalid}), 256'(2'b00));
    chk("rst_mid_regs", 256'(regs), 256'(exp_regs));
    wvalid = 1'b1; wdata = 32'h77777777; wstrb = 4'hF;
    tick();
    wvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("stale_no_bvalid", 256'(bvalid), 256'(1'b0));
      chk("stale_regs", 256'(regs), 256'(exp_regs));
      tick();
    end
    awvalid = 1'b1; awaddr = 32'h18; awid = 4'd3;
    tick();
    awvalid = 1'b0;
    exp_regs[6*DW +: DW] = 32'h77777777;
    chk("fresh_bvalid", 256'(bvalid), 256'(1'b1));
    chk("fresh_bid", 256'(bid), 256'(4'd3));
    chk("fresh_regs", 256'(regs), 256'(exp_regs));
    finish_b();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
